// File: rtl/encoder_2to4_pkg.sv
// Shared defaults, the index-width helper and the request/index types for the
// registered priority encoder.
package encoder_2to4_pkg;

    localparam int unsigned WIDTH = 4;

    // Index width for a given request width (ceil(log2(w)))
    function automatic int unsigned out_w_of(input int unsigned w);
        int unsigned n;
        n = 0;
        while ((32'd1 << n) < w) begin
            n = n + 1;
        end
        return n;
    endfunction

    localparam int unsigned OUT_W = out_w_of(WIDTH);

    typedef logic [WIDTH-1:0] req_t;
    typedef logic [OUT_W-1:0] idx_t;

endpackage

// File: rtl/encoder_2to4_prio_enc_core.sv
// Combinational fixed-priority encoder: the highest-numbered set bit wins.
module prio_enc_core
    import encoder_2to4_pkg::*;
#(
    parameter int unsigned WIDTH = encoder_2to4_pkg::WIDTH,
    localparam int unsigned OUT_W = out_w_of(WIDTH)
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [OUT_W-1:0] o_idx,
    output logic             o_any,
    output logic [WIDTH-1:0] o_onehot
);

    // Upward scan: each later hit overwrites the earlier one
    always_comb begin
        o_idx    = '0;
        o_any    = 1'b0;
        o_onehot = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (i_req[k]) begin
                o_idx       = OUT_W'(k);
                o_any       = 1'b1;
                o_onehot    = '0;
                o_onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_2to4.sv
// Registered priority encoder with enable; one output register stage and a
// synchronous active-high reset.
module encoder_2to4
    import encoder_2to4_pkg::*;
#(
    parameter int unsigned WIDTH = encoder_2to4_pkg::WIDTH,
    localparam int unsigned OUT_W = out_w_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] i,
    output logic [OUT_W-1:0] y,
    output logic             valid,
    output logic [WIDTH-1:0] onehot
);

    if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
        $fatal(1, "encoder_2to4: WIDTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] w_req;
    logic [OUT_W-1:0] w_idx;
    logic             w_any;
    logic [WIDTH-1:0] w_onehot;

    logic [OUT_W-1:0] r_y;
    logic             r_valid;
    logic [WIDTH-1:0] r_onehot;

    // Gate before encoding so unknowns on i cannot reach the outputs while disabled
    assign w_req = i & {WIDTH{en}};

    prio_enc_core #(.WIDTH(WIDTH)) u_core (
        .i_req    (w_req),
        .o_idx    (w_idx),
        .o_any    (w_any),
        .o_onehot (w_onehot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y      <= '0;
            r_valid  <= 1'b0;
            r_onehot <= '0;
        end else begin
            r_y      <= w_idx;
            r_valid  <= w_any;
            r_onehot <= w_onehot;
        end
    end

    assign y      = r_y;
    assign valid  = r_valid;
    assign onehot = r_onehot;

endmodule

// File: tb/tb_encoder_2to4.sv
// Scoreboard bench for encoder_2to4 at WIDTH=4 and WIDTH=8.
module tb_encoder_2to4;

    typedef struct packed {
        logic [2:0] y;
        logic       v;
        logic [7:0] oh;
    } exp_t;

    logic       clk;
    logic       rst, en;
    logic [3:0] i;
    logic [1:0] y;
    logic       valid;
    logic [3:0] onehot;

    logic       rst8, en8;
    logic [7:0] i8;
    logic [2:0] y8;
    logic       valid8;
    logic [7:0] onehot8;

    exp_t q4[$];
    exp_t q8[$];
    int   total = 0;
    int   bad   = 0;

    encoder_2to4 #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .i(i),
        .y(y), .valid(valid), .onehot(onehot)
    );

    encoder_2to4 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .i(i8),
        .y(y8), .valid(valid8), .onehot(onehot8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: a result is presented every cycle; pop one expectation per edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q4.size() > 0) begin
                e = q4.pop_front();
                chk("w4_y",      8'(y),      8'(e.y));
                chk("w4_valid",  8'(valid),  8'(e.v));
                chk("w4_onehot", 8'(onehot), e.oh);
                chk("w4_noX",    8'($isunknown({y, valid, onehot})), 8'd0);
            end
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk("w8_y",      8'(y8),      8'(e.y));
                chk("w8_valid",  8'(valid8),  8'(e.v));
                chk("w8_onehot", onehot8,     e.oh);
            end
        end
    end

    task automatic drv4(input logic r, input logic e, input logic [3:0] req,
                        input logic [1:0] ey, input logic ev, input logic [3:0] eoh);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; i = req;
        x.y = 3'(ey); x.v = ev; x.oh = 8'(eoh);
        q4.push_back(x);
    endtask

    task automatic drv8(input logic r, input logic e, input logic [7:0] req,
                        input logic [2:0] ey, input logic ev, input logic [7:0] eoh);
        exp_t x;
        @(negedge clk);
        rst8 = r; en8 = e; i8 = req;
        x.y = ey; x.v = ev; x.oh = eoh;
        q8.push_back(x);
    endtask

    initial begin
        int guard;
        rst = 1'b1; en = 1'b0; i = 4'h0;
        rst8 = 1'b1; en8 = 1'b0; i8 = 8'h00;

        // Reset held two cycles with a live request, then release
        drv4(1, 1, 4'b1000, 0, 0, 4'b0000);
        drv4(1, 1, 4'b1000, 0, 0, 4'b0000);
        drv4(0, 1, 4'b1000, 3, 1, 4'b1000);
        // Single-bit sweep
        drv4(0, 1, 4'b1000, 3, 1, 4'b1000);
        drv4(0, 1, 4'b0100, 2, 1, 4'b0100);
        drv4(0, 1, 4'b0010, 1, 1, 4'b0010);
        drv4(0, 1, 4'b0001, 0, 1, 4'b0001);
        // No request, then disabled with unknown input
        drv4(0, 1, 4'b0000, 0, 0, 4'b0000);
        drv4(0, 0, 4'bxxxx, 0, 0, 4'b0000);
        drv4(0, 0, 4'b1111, 0, 0, 4'b0000);
        // Multi-bit priority
        drv4(0, 1, 4'b0110, 2, 1, 4'b0100);
        drv4(0, 1, 4'b1111, 3, 1, 4'b1000);
        drv4(0, 1, 4'b0011, 1, 1, 4'b0010);
        drv4(0, 1, 4'b0101, 2, 1, 4'b0100);
        // Mid-stream reset
        drv4(0, 1, 4'b1000, 3, 1, 4'b1000);
        drv4(1, 1, 4'b1000, 0, 0, 4'b0000);
        drv4(0, 1, 4'b1000, 3, 1, 4'b1000);
        drv4(0, 1, 4'b1000, 3, 1, 4'b1000);

        // WIDTH=8 instance
        drv8(1, 1, 8'h80, 0, 0, 8'h00);
        drv8(0, 1, 8'h80, 7, 1, 8'h80);
        drv8(0, 1, 8'h40, 6, 1, 8'h40);
        drv8(0, 1, 8'h10, 4, 1, 8'h10);
        drv8(0, 1, 8'h01, 0, 1, 8'h01);
        drv8(0, 1, 8'h3c, 5, 1, 8'h20);
        drv8(0, 1, 8'h00, 0, 0, 8'h00);
        drv8(0, 0, 8'hff, 0, 0, 8'h00);

        // Drain with a bounded wait
        guard = 0;
        while ((q4.size() > 0 || q8.size() > 0) && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        #2;
        total++;
        if (q4.size() != 0 || q8.size() != 0) begin
            bad++;
            $display("FAIL drain: pending %0d/%0d expected 0/0", q4.size(), q8.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
